// File: rtl/pfl_page_sequencer.sv
// pfl_page_sequencer
// Boot / reconfiguration sequencer sitting between the system controller,
// the flash page-select reader and the PFL core. It arbitrates the flash bus,
// selects the configuration page, generates the nCONFIG / nRESET pulses
// towards the PFL and supervises CONF_DONE with a timeout and per-page retry.
//
// Optional build macro: PFL_SEQ_FALLBACK_EN
//   defined   : a page other than 0 that exhausts its retries falls back to
//               page 0 and fallback_active is raised.
//   undefined : retry exhaustion always ends in ERROR; fallback_active stays 0.
module pfl_page_sequencer #(
    parameter int NUM_PAGES        = 4,
    parameter int PAGE_W           = 3,
    parameter int CFG_PULSE_CYC    = 16,
    parameter int RST_PULSE_CYC    = 16,
    parameter int DONE_TIMEOUT_CYC = 1 << 24,
    parameter int MAX_RETRY        = 2
) (
    input  logic              clkin_max_100,
    input  logic              sys_reset,
    input  logic              fpga_conf_done,
    input  logic              sel_valid,
    input  logic [PAGE_W-1:0] sel_page,
    output logic              fl_rd_req,
    output logic              pfl_grant,
    input  logic              reconfig_req,
    input  logic [PAGE_W-1:0] reconfig_page,
    output logic [PAGE_W-1:0] fpga_pgm,
    output logic              pfl_nreconfigure,
    output logic              pfl_nreset,
    output logic              busy,
    output logic              cfg_error,
    output logic              fallback_active,
    output logic [PAGE_W-1:0] cur_page
);

    // ------------------------------------------------------------------
    // Derived sizes and terminal counts
    // ------------------------------------------------------------------
    localparam int SYNC_STAGES = 2;
    localparam int PULSE_MAX   = (CFG_PULSE_CYC > RST_PULSE_CYC) ? CFG_PULSE_CYC : RST_PULSE_CYC;
    localparam int PULSE_W     = $clog2(PULSE_MAX + 1);
    localparam int TO_W        = (DONE_TIMEOUT_CYC > 1) ? $clog2(DONE_TIMEOUT_CYC) : 1;
    localparam int RETRY_W     = $clog2(MAX_RETRY + 1);

    localparam logic [PULSE_W-1:0] CFG_LAST  = PULSE_W'(CFG_PULSE_CYC - 1);
    localparam logic [PULSE_W-1:0] RST_LAST  = PULSE_W'(RST_PULSE_CYC - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(DONE_TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_SAT = RETRY_W'(MAX_RETRY);

    // State encoding kept as plain constants so existing decode tables still apply
    localparam logic [3:0] ST_POWERON   = 4'd0;
    localparam logic [3:0] ST_READ_SEL  = 4'd1;
    localparam logic [3:0] ST_ARM       = 4'd2;
    localparam logic [3:0] ST_NRECONF   = 4'd3;
    localparam logic [3:0] ST_NRST      = 4'd4;
    localparam logic [3:0] ST_WAIT_DONE = 4'd5;
    localparam logic [3:0] ST_FAIL      = 4'd6;
    localparam logic [3:0] ST_IDLE      = 4'd7;
    localparam logic [3:0] ST_ERROR     = 4'd8;

    // Pages outside the populated range are redirected to the golden page 0
    function automatic logic [PAGE_W-1:0] clamp_page(input logic [PAGE_W-1:0] p);
        return (int'(p) >= NUM_PAGES) ? '0 : p;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   conf_done_s;

    logic [3:0]         state_reg,      state_next;
    logic [PAGE_W-1:0]  target_reg,     target_next;
    logic [RETRY_W-1:0] retry_reg,      retry_next;
    logic [TO_W-1:0]    to_cnt_reg,     to_cnt_next;
    logic [PULSE_W-1:0] pulse_cnt_reg,  pulse_cnt_next;
    logic               seen_low_reg,   seen_low_next;

    logic               fl_rd_req_reg,  fl_rd_req_next;
    logic               pfl_grant_reg,  pfl_grant_next;
    logic [PAGE_W-1:0]  fpga_pgm_reg,   fpga_pgm_next;
    logic               nreconf_reg,    nreconf_next;
    logic               nreset_reg,     nreset_next;
    logic               busy_reg,       busy_next;
    logic               cfg_error_reg,  cfg_error_next;
    logic               fallback_reg,   fallback_next;

    // Helpers shared by every path that (re)starts a pulse sequence
    logic               arm_go;
    logic [PAGE_W-1:0]  arm_page;
    logic [RETRY_W-1:0] retry_inc;

    // CONF_DONE comes from the FPGA pin domain: two-flop synchroniser
    always_ff @(posedge clkin_max_100) begin
        if (sys_reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], fpga_conf_done};
        end
    end

    assign conf_done_s = sync_reg[SYNC_STAGES-1];

    // Next-state and next-output decode; outputs are computed for the state being entered
    always_comb begin
        state_next     = state_reg;
        target_next    = target_reg;
        retry_next     = retry_reg;
        to_cnt_next    = to_cnt_reg;
        pulse_cnt_next = pulse_cnt_reg;
        seen_low_next  = seen_low_reg;
        fl_rd_req_next = fl_rd_req_reg;
        pfl_grant_next = pfl_grant_reg;
        fpga_pgm_next  = fpga_pgm_reg;
        nreconf_next   = nreconf_reg;
        nreset_next    = nreset_reg;
        busy_next      = busy_reg;
        cfg_error_next = cfg_error_reg;
        fallback_next  = fallback_reg;
        arm_go         = 1'b0;
        arm_page       = target_reg;
        retry_inc      = (retry_reg == RETRY_SAT) ? retry_reg : retry_reg + RETRY_W'(1);

        case (state_reg)
            ST_POWERON: begin
                // sel_valid is deliberately not looked at here
                if (to_cnt_reg != TO_LAST) begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
                if (conf_done_s || (to_cnt_reg == TO_LAST)) begin
                    state_next     = ST_READ_SEL;
                    pfl_grant_next = 1'b0;
                    fl_rd_req_next = 1'b1;
                end
            end

            ST_READ_SEL: begin
                if (sel_valid) begin
                    target_next = clamp_page(sel_page);
                    retry_next  = '0;
                    arm_go      = 1'b1;
                    arm_page    = clamp_page(sel_page);
                end
            end

            ST_ARM: begin
                state_next     = ST_NRECONF;
                nreconf_next   = 1'b0;
                pulse_cnt_next = '0;
            end

            ST_NRECONF: begin
                if (pulse_cnt_reg == CFG_LAST) begin
                    // nRESET falls on the very edge nCONFIG rises
                    state_next     = ST_NRST;
                    nreconf_next   = 1'b1;
                    nreset_next    = 1'b0;
                    pulse_cnt_next = '0;
                end else begin
                    pulse_cnt_next = pulse_cnt_reg + PULSE_W'(1);
                end
            end

            ST_NRST: begin
                if (pulse_cnt_reg == RST_LAST) begin
                    state_next    = ST_WAIT_DONE;
                    nreset_next   = 1'b1;
                    to_cnt_next   = '0;
                    seen_low_next = 1'b0;
                end else begin
                    pulse_cnt_next = pulse_cnt_reg + PULSE_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                // A stale high CONF_DONE from the previous image must not count:
                // success needs a low sample first, then a high one.
                if (!conf_done_s) begin
                    seen_low_next = 1'b1;
                end
                if (seen_low_reg && conf_done_s) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    retry_next = '0;
                end else if (to_cnt_reg == TO_LAST) begin
                    state_next = ST_FAIL;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end

            ST_FAIL: begin
                retry_next = retry_inc;
                if (int'(retry_inc) < MAX_RETRY) begin
                    arm_go   = 1'b1;
                    arm_page = target_reg;
                end
`ifdef PFL_SEQ_FALLBACK_EN
                else if (target_reg != '0) begin
                    target_next   = '0;
                    retry_next    = '0;
                    fallback_next = 1'b1;
                    arm_go        = 1'b1;
                    arm_page      = '0;
                end
`endif
                else begin
                    state_next     = ST_ERROR;
                    busy_next      = 1'b0;
                    cfg_error_next = 1'b1;
                end
            end

            ST_IDLE, ST_ERROR: begin
                if (reconfig_req) begin
                    target_next    = clamp_page(reconfig_page);
                    retry_next     = '0;
                    fallback_next  = 1'b0;
                    cfg_error_next = 1'b0;
                    arm_go         = 1'b1;
                    arm_page       = clamp_page(reconfig_page);
                end
            end

            default: begin
                // Unreachable encodings recover through the power-on path
                state_next     = ST_POWERON;
                to_cnt_next    = '0;
                fl_rd_req_next = 1'b0;
                pfl_grant_next = 1'b1;
                nreconf_next   = 1'b1;
                nreset_next    = 1'b1;
                busy_next      = 1'b1;
            end
        endcase

        // Common entry into ARM: PFL takes the bus and the page is latched
        if (arm_go) begin
            state_next     = ST_ARM;
            pfl_grant_next = 1'b1;
            fl_rd_req_next = 1'b0;
            fpga_pgm_next  = arm_page;
            busy_next      = 1'b1;
        end
    end

    // State and registered outputs; reset aborts any pulse in progress
    always_ff @(posedge clkin_max_100) begin
        if (sys_reset) begin
            state_reg     <= ST_POWERON;
            target_reg    <= '0;
            retry_reg     <= '0;
            to_cnt_reg    <= '0;
            pulse_cnt_reg <= '0;
            seen_low_reg  <= 1'b0;
            fl_rd_req_reg <= 1'b0;
            pfl_grant_reg <= 1'b1;
            fpga_pgm_reg  <= '0;
            nreconf_reg   <= 1'b1;
            nreset_reg    <= 1'b1;
            busy_reg      <= 1'b1;
            cfg_error_reg <= 1'b0;
            fallback_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            target_reg    <= target_next;
            retry_reg     <= retry_next;
            to_cnt_reg    <= to_cnt_next;
            pulse_cnt_reg <= pulse_cnt_next;
            seen_low_reg  <= seen_low_next;
            fl_rd_req_reg <= fl_rd_req_next;
            pfl_grant_reg <= pfl_grant_next;
            fpga_pgm_reg  <= fpga_pgm_next;
            nreconf_reg   <= nreconf_next;
            nreset_reg    <= nreset_next;
            busy_reg      <= busy_next;
            cfg_error_reg <= cfg_error_next;
            fallback_reg  <= fallback_next;
        end
    end

    assign fl_rd_req        = fl_rd_req_reg;
    assign pfl_grant        = pfl_grant_reg;
    assign fpga_pgm         = fpga_pgm_reg;
    assign cur_page         = fpga_pgm_reg;
    assign pfl_nreconfigure = nreconf_reg;
    assign pfl_nreset       = nreset_reg;
    assign busy             = busy_reg;
    assign cfg_error        = cfg_error_reg;
    assign fallback_active  = fallback_reg;

endmodule

// File: tb/tb_pfl_page_sequencer.sv
// tb_pfl_page_sequencer
// Directed + randomized bench for pfl_page_sequencer. A negedge monitor
// records every nCONFIG/nRESET pulse; a page-level reference model predicts
// the list of attempted pages and the final status of each transaction.
module tb_pfl_page_sequencer;

    localparam int NUM_PAGES        = 4;
    localparam int PAGE_W           = 3;
    localparam int CFG_PULSE_CYC    = 16;
    localparam int RST_PULSE_CYC    = 16;
    localparam int DONE_TIMEOUT_CYC = 64;
    localparam int MAX_RETRY        = 2;

    logic              clk = 1'b0;
    logic              sys_reset;
    logic              fpga_conf_done;
    logic              sel_valid;
    logic [PAGE_W-1:0] sel_page;
    logic              fl_rd_req;
    logic              pfl_grant;
    logic              reconfig_req;
    logic [PAGE_W-1:0] reconfig_page;
    logic [PAGE_W-1:0] fpga_pgm;
    logic              pfl_nreconfigure;
    logic              pfl_nreset;
    logic              busy;
    logic              cfg_error;
    logic              fallback_active;
    logic [PAGE_W-1:0] cur_page;

    always #5 clk = ~clk;

    pfl_page_sequencer #(
        .NUM_PAGES        (NUM_PAGES),
        .PAGE_W           (PAGE_W),
        .CFG_PULSE_CYC    (CFG_PULSE_CYC),
        .RST_PULSE_CYC    (RST_PULSE_CYC),
        .DONE_TIMEOUT_CYC (DONE_TIMEOUT_CYC),
        .MAX_RETRY        (MAX_RETRY)
    ) dut (
        .clkin_max_100    (clk),
        .sys_reset        (sys_reset),
        .fpga_conf_done   (fpga_conf_done),
        .sel_valid        (sel_valid),
        .sel_page         (sel_page),
        .fl_rd_req        (fl_rd_req),
        .pfl_grant        (pfl_grant),
        .reconfig_req     (reconfig_req),
        .reconfig_page    (reconfig_page),
        .fpga_pgm         (fpga_pgm),
        .pfl_nreconfigure (pfl_nreconfigure),
        .pfl_nreset       (pfl_nreset),
        .busy             (busy),
        .cfg_error        (cfg_error),
        .fallback_active  (fallback_active),
        .cur_page         (cur_page)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // Pulse monitor
    // ------------------------------------------------------------------
    logic [PAGE_W-1:0] pulse_pages[$];
    int                nrc_widths[$];
    int                nrs_widths[$];
    int                nrc_w = 0;
    int                nrs_w = 0;
    int                grant_viol = 0;
    int                align_viol = 0;
    logic              nrc_d = 1'b1;
    logic              nrs_d = 1'b1;

    always @(negedge clk) begin
        if (sys_reset === 1'b1) begin
            nrc_d = 1'b1;
            nrs_d = 1'b1;
            nrc_w = 0;
            nrs_w = 0;
        end else begin
            if (pfl_nreconfigure === 1'b0) begin
                if (nrc_d) pulse_pages.push_back(fpga_pgm);
                nrc_w++;
            end else if (!nrc_d) begin
                nrc_widths.push_back(nrc_w);
                nrc_w = 0;
                if (pfl_nreset !== 1'b0) align_viol++;
            end
            if (pfl_nreset === 1'b0) begin
                nrs_w++;
            end else if (!nrs_d) begin
                nrs_widths.push_back(nrs_w);
                nrs_w = 0;
            end
            if (pfl_grant === 1'b0 && (pfl_nreconfigure === 1'b0 || pfl_nreset === 1'b0))
                grant_viol++;
            nrc_d = pfl_nreconfigure;
            nrs_d = pfl_nreset;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: attempted pages and final status from the rules
    // ------------------------------------------------------------------
    int exp_pages[$];
    int exp_err;
    int exp_fb;

    function automatic int clamp(input int p);
        return (p >= NUM_PAGES) ? 0 : p;
    endfunction

    function automatic void model_run(input int start, input logic [15:0] ok);
        int  page;
        int  retry;
        int  att;
        bit  done;
        exp_pages.delete();
        exp_err = 0;
        exp_fb  = 0;
        page    = clamp(start);
        retry   = 0;
        att     = 0;
        done    = 0;
        while (!done && att < 16) begin
            exp_pages.push_back(page);
            if (ok[att]) begin
                done = 1;
            end else begin
                att++;
                retry++;
                if (retry >= MAX_RETRY) begin
`ifdef PFL_SEQ_FALLBACK_EN
                    if (page != 0) begin
                        page   = 0;
                        retry  = 0;
                        exp_fb = 1;
                    end else begin
                        exp_err = 1;
                        done    = 1;
                    end
`else
                    exp_err = 1;
                    done    = 1;
`endif
                end
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Acts as the FPGA: per attempt, either toggles CONF_DONE low->high or leaves it stuck high
    task automatic serve(input logic [15:0] ok, input bit inject, input logic [PAGE_W-1:0] inj_page);
        int n;
        for (int i = 0; i < 16; i++) begin
            n = 0;
            while (pfl_nreset === 1'b1 && busy === 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("serve_wait_nrst_or_done", (n < 200), 1);
            if (n >= 200 || busy !== 1'b1) break;
            n = 0;
            while (pfl_nreset === 1'b0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("serve_wait_nrst_rise", (n < 100), 1);
            if (n >= 100) break;
            if (inject && i == 0) begin
                reconfig_req  = 1'b1;
                reconfig_page = inj_page;
                @(negedge clk);
                reconfig_req  = 1'b0;
            end
            if (ok[i]) begin
                fpga_conf_done = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                fpga_conf_done = 1'b1;
            end
        end
    endtask

    task automatic run_txn(input bit use_sel, input int page, input logic [15:0] ok,
                           input bit inject, input int inj_page);
        logic [PAGE_W-1:0] pg_exp;
        int                last;
        pg_exp = PAGE_W'(clamp(page));
        model_run(page, ok);
        pulse_pages.delete();
        nrc_widths.delete();
        nrs_widths.delete();
        grant_viol = 0;
        align_viol = 0;
        if (use_sel) begin
            sel_valid = 1'b1;
            sel_page  = PAGE_W'(page);
        end else begin
            reconfig_req  = 1'b1;
            reconfig_page = PAGE_W'(page);
        end
        @(negedge clk);
        sel_valid    = 1'b0;
        reconfig_req = 1'b0;
        check("arm_fpga_pgm", fpga_pgm, pg_exp);
        check("arm_nreconf_high", pfl_nreconfigure, 1);
        check("arm_grant", pfl_grant, 1);
        check("arm_rd_req", fl_rd_req, 0);
        check("arm_busy", busy, 1);
        check("arm_cfg_error", cfg_error, 0);
        check("arm_fallback", fallback_active, 0);
        @(negedge clk);
        check("nreconf_low_latency", pfl_nreconfigure, 0);
        serve(ok, inject, PAGE_W'(inj_page));
        repeat (3) @(negedge clk);
        last = exp_pages[exp_pages.size() - 1];
        check("attempt_count", pulse_pages.size(), exp_pages.size());
        for (int i = 0; i < exp_pages.size() && i < pulse_pages.size(); i++)
            check("attempt_page", pulse_pages[i], exp_pages[i]);
        check("nreconf_pulse_count", nrc_widths.size(), exp_pages.size());
        foreach (nrc_widths[i]) check("nreconf_width", nrc_widths[i], CFG_PULSE_CYC);
        check("nreset_pulse_count", nrs_widths.size(), exp_pages.size());
        foreach (nrs_widths[i]) check("nreset_width", nrs_widths[i], RST_PULSE_CYC);
        check("nreset_follows_nreconf", align_viol, 0);
        check("grant_during_pulse", grant_viol, 0);
        check("end_busy", busy, 0);
        check("end_cfg_error", cfg_error, exp_err);
        check("end_fallback", fallback_active, exp_fb);
        check("end_fpga_pgm", fpga_pgm, last);
        check("end_cur_page", cur_page, last);
        $display("txn sel=%0d page=%0d ok=%04h attempts=%0d err=%0d fb=%0d last=%0d",
                 use_sel, page, ok, pulse_pages.size(), cfg_error, fallback_active, cur_page);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence followed by randomized transactions
    // ------------------------------------------------------------------
    initial begin
        int n;
        sys_reset      = 1'b1;
        fpga_conf_done = 1'b0;
        sel_valid      = 1'b0;
        sel_page       = '0;
        reconfig_req   = 1'b0;
        reconfig_page  = '0;
        repeat (3) @(negedge clk);

        check("rst_grant", pfl_grant, 1);
        check("rst_rd_req", fl_rd_req, 0);
        check("rst_nreconf", pfl_nreconfigure, 1);
        check("rst_nreset", pfl_nreset, 1);
        check("rst_fpga_pgm", fpga_pgm, 0);
        check("rst_busy", busy, 1);
        check("rst_cfg_error", cfg_error, 0);
        check("rst_fallback", fallback_active, 0);

        // Power-on timeout with CONF_DONE low; sel_valid coincides with the timeout
        sys_reset = 1'b0;
        repeat (DONE_TIMEOUT_CYC - 1) @(negedge clk);
        check("poweron_still_waiting", fl_rd_req, 0);
        sel_valid = 1'b1;
        sel_page  = 3'd3;
        @(negedge clk);
        sel_valid = 1'b0;
        check("poweron_timeout_rd_req", fl_rd_req, 1);
        check("read_sel_grant", pfl_grant, 0);
        repeat (2) @(negedge clk);
        check("sel_in_poweron_ignored", fl_rd_req, 1);
        check("sel_in_poweron_no_pulse", pfl_nreconfigure, 1);
        fpga_conf_done = 1'b1;

        run_txn(1'b1, 2, 16'h0001, 1'b0, 0);
        run_txn(1'b0, 7, 16'h0001, 1'b0, 0);
        run_txn(1'b0, 1, 16'h0000, 1'b0, 0);
        run_txn(1'b0, 1, 16'h0001, 1'b0, 0);
        run_txn(1'b0, 3, 16'h0004, 1'b0, 0);
        run_txn(1'b0, 2, 16'h0001, 1'b1, 1);

        for (int k = 0; k < 6; k++)
            run_txn(1'b0, $urandom_range(0, 7), 16'($urandom), 1'b0, 0);

        // Reset in the middle of the nCONFIG pulse
        reconfig_req  = 1'b1;
        reconfig_page = 3'd2;
        @(negedge clk);
        reconfig_req  = 1'b0;
        n = 0;
        while (pfl_nreconfigure === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach_nreconf", (n < 20), 1);
        repeat (4) @(negedge clk);
        sys_reset = 1'b1;
        @(negedge clk);
        check("midrst_nreconf", pfl_nreconfigure, 1);
        check("midrst_nreset", pfl_nreset, 1);
        check("midrst_grant", pfl_grant, 1);
        check("midrst_busy", busy, 1);
        check("midrst_fpga_pgm", fpga_pgm, 0);
        check("midrst_rd_req", fl_rd_req, 0);
        sys_reset = 1'b0;
        n = 0;
        while (fl_rd_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("midrst_poweron_to_read_sel", (n <= 5), 1);

        run_txn(1'b1, $urandom_range(0, 7), 16'($urandom), 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
